pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_ctrl_hazard_det.sv | 22 ++
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: controller state encodings and
// the field values that make up a decode-to-ALU NOP bubble.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  // A bubble is an all-zero instruction slot that writes no register.
  localparam logic       NOP_RD_REG_EN  = 1'b0;
  localparam logic [4:0] NOP_RD_ADDR    = 5'd0;
  localparam logic [4:0] NOP_RS_ADDR    = 5'd0;
  localparam logic       NOP_IS_LOAD    = 1'b0;
  localparam logic       NOP_MDIV_REQ   = 1'b0;

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard detect: a decode-stage source matches the non-x0 destination
// of a load sitting in the ALU stage. Pure combinational.
module pipe_ctrl_hazard_det (
  input  logic       de_rs1_en,
  input  logic       de_rs2_en,
  input  logic [4:0] de_rs1_addr,
  input  logic [4:0] de_rs2_addr,
  input  logic       alu_rd_reg_en,
  input  logic [4:0] alu_rd_reg_addr,
  input  logic       alu_is_load,
  output logic       lu
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = de_rs1_en & (de_rs1_addr == alu_rd_reg_addr);
  assign rs2_match = de_rs2_en & (de_rs2_addr == alu_rd_reg_addr);
  assign lu = alu_is_load & alu_rd_reg_en & (alu_rd_reg_addr != 5'd0)
            & (rs1_match | rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flush, and the
// multi-cycle mul/div handshake with timeout. Control outputs are combinational.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MDIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_rs1_en,
  input  logic        de_rs2_en,
  input  logic [4:0]  de_rs1_addr,
  input  logic [4:0]  de_rs2_addr,
  input  logic        alu_rd_reg_en,
  input  logic [4:0]  alu_rd_reg_addr,
  input  logic        alu_is_load,
  input  logic        alu_mdiv_req,
  input  logic        mdiv_done,
  input  logic        branch_taken,
  input  logic        stall_cnt_clr,
  output logic        fe_stall,
  output logic        de_stall,
  output logic        de_bubble,
  output logic        alu_hold,
  output logic        flush,
  output logic        mdiv_start,
  output logic        mdiv_err,
  output logic [15:0] stall_cnt
);

  localparam logic [7:0] FLUSH_LOAD   = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] MDIV_LAST    = 8'(MDIV_TIMEOUT - 1);

  logic        lu;
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mdiv_err_q, mdiv_err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic fe_stall_c, de_stall_c, de_bubble_c, alu_hold_c, flush_c, mdiv_start_c;

  pipe_ctrl_hazard_det u_hazard_det (
    .de_rs1_en       (de_rs1_en),
    .de_rs2_en       (de_rs2_en),
    .de_rs1_addr     (de_rs1_addr),
    .de_rs2_addr     (de_rs2_addr),
    .alu_rd_reg_en   (alu_rd_reg_en),
    .alu_rd_reg_addr (alu_rd_reg_addr),
    .alu_is_load     (alu_is_load),
    .lu              (lu)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mdiv_err_d   = mdiv_err_q;
    fe_stall_c   = 1'b0;
    de_stall_c   = 1'b0;
    de_bubble_c  = 1'b0;
    alu_hold_c   = 1'b0;
    flush_c      = 1'b0;
    mdiv_start_c = 1'b0;

    case (state_q)
      RUN: begin
        if (branch_taken) begin
          flush_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end else if (alu_mdiv_req) begin
          mdiv_start_c = 1'b1;
          fe_stall_c   = 1'b1;
          de_stall_c   = 1'b1;
          alu_hold_c   = 1'b1;
          state_d      = MD_WAIT;
          cnt_d        = 8'd0;
        end else if (lu) begin
          fe_stall_c  = 1'b1;
          de_stall_c  = 1'b1;
          de_bubble_c = 1'b1;
        end
      end

      MD_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mdiv_done) begin
          state_d = RUN;
        end else if (cnt_q == MDIV_LAST) begin
          // Give up on the unit; release the pipe and leave a sticky flag.
          mdiv_err_d = 1'b1;
          state_d    = RUN;
        end else begin
          fe_stall_c = 1'b1;
          de_stall_c = 1'b1;
          alu_hold_c = 1'b1;
        end
      end

      FLUSH: begin
        flush_c = 1'b1;
        cnt_d   = cnt_q - 8'd1;
        // The branch cycle already flushed once, so leave when the count runs out.
        if (cnt_q <= 8'd1) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr) begin
      stall_cnt_d = 16'd0;
    end else if (de_stall_c && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 8'd0;
      mdiv_err_q  <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mdiv_err_q  <= mdiv_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Gate with rst_n so nothing leaks out while reset is asserted.
  assign fe_stall   = fe_stall_c   & rst_n;
  assign de_stall   = de_stall_c   & rst_n;
  assign de_bubble  = de_bubble_c  & rst_n;
  assign alu_hold   = alu_hold_c   & rst_n;
  assign flush      = flush_c      & rst_n;
  assign mdiv_start = mdiv_start_c & rst_n;
  assign mdiv_err   = mdiv_err_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
